// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM encoding, debug view, clock rate.
// Optional continuous mode is selected by the PERIOD_METER_AUTO_EN macro (see period_meter.sv).
package period_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW,
        DONE
    } pm_state_t;

    typedef struct packed {
        pm_state_t state;
        logic      level;
    } pm_dbg_t;

    localparam int CLK_50_HZ       = 50_000_000;
    localparam int TIMEOUT_DEFAULT = CLK_50_HZ;

endpackage

// File: rtl/period_meter_if.sv
// Request/result bundle between the period meter (master) and its consumer (slave).
// Handshake: start is sampled only when the meter is idle; a result is transferred on
// the cycle where valid and rdy are both high, and valid/data stay stable until then.
interface period_meter_if #(
    parameter int CNT_W = 26
);
    logic             start;
    logic             rdy;
    logic             busy;
    logic             valid;
    logic             timeout;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    modport master (
        input  start, rdy,
        output busy, valid, timeout, period, high_time
    );

    modport slave (
        output start, rdy,
        input  busy, valid, timeout, period, high_time
    );
endinterface

// File: rtl/period_meter_sync_edge.sv
// Synchroniser plus one history flop; produces single-cycle rise/fall pulses with
// identical latency for both edges so measured widths are exact.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50,
    input  logic reset,
    input  logic d_async,
    output logic rise,
    output logic fall,
    output logic level
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;
endmodule

// File: rtl/period_meter.sv
// Measures period and high time of sig_in in clk_50 cycles, one result per start.
// Define PERIOD_METER_AUTO_EN to re-arm automatically after each handshake.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = 26,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_50,
    input  logic                  reset,
    input  logic                  sig_in,
    period_meter_if.master        bus,
    output pm_dbg_t               dbg
);
    logic rise, fall, level;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_50  (clk_50),
        .reset   (reset),
        .d_async (sig_in),
        .rise    (rise),
        .fall    (fall),
        .level   (level)
    );

    pm_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] period_q, period_n;
    logic [CNT_W-1:0] high_q, high_n;
    logic             valid_q, valid_n;
    logic             tmo_q, tmo_n;
    logic             busy_q, busy_n;
    logic             at_limit;

    assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        period_n = period_q;
        high_n   = high_q;
        valid_n  = valid_q;
        tmo_n    = tmo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_n   = '0;
                    state_n = WAIT_RISE;
                end
            end
            WAIT_RISE, MEAS_HIGH, MEAS_LOW: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (state_q == WAIT_RISE && rise) begin
                    cnt_n   = CNT_W'(1);
                    state_n = MEAS_HIGH;
                end else if (state_q == MEAS_HIGH && fall) begin
                    high_n  = cnt_q;
                    state_n = MEAS_LOW;
                end else if (state_q == MEAS_LOW && rise) begin
                    period_n = cnt_q;
                    valid_n  = 1'b1;
                    tmo_n    = 1'b0;
                    state_n  = DONE;
                end else if (at_limit) begin
                    // Edge wins over the limit; only an edge-less limit cycle aborts.
                    period_n = '0;
                    high_n   = '0;
                    valid_n  = 1'b1;
                    tmo_n    = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE: begin
                if (valid_q && bus.rdy) begin
                    valid_n = 1'b0;
                    tmo_n   = 1'b0;
`ifdef PERIOD_METER_AUTO_EN
                    cnt_n   = '0;
                    state_n = WAIT_RISE;
`else
                    state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            period_q <= period_n;
            high_q   <= high_n;
            valid_q  <= valid_n;
            tmo_q    <= tmo_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = tmo_q;
    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign dbg.state     = state_q;
    assign dbg.level     = level;
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed steps plus randomized waveforms,
// results predicted from waveform high/low lengths (high_time=N, period=N+M).
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int CNT_W = 26;
    localparam int TMO   = 1000;
    localparam int EW    = 1 + 2 * CNT_W;

    logic    clk_50 = 1'b0;
    logic    reset;
    logic    sig_in;
    pm_dbg_t dbg;

    period_meter_if #(.CNT_W(CNT_W)) bus ();

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .sig_in (sig_in),
        .bus    (bus),
        .dbg    (dbg)
    );

    // clock / watchdog
    always #10 clk_50 = ~clk_50;

    initial begin
        #(20 * 80000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // waveform generator: mode 0 = square wave gen_hi/gen_lo, mode 1 = constant gen_level
    int   gen_hi    = 8;
    int   gen_lo    = 8;
    bit   gen_mode  = 1'b1;
    logic gen_level = 1'b0;

    initial begin
        sig_in = 1'b0;
        forever begin
            if (gen_mode) begin
                @(negedge clk_50);
                sig_in = gen_level;
            end else begin
                sig_in = 1'b1;
                repeat (gen_hi) @(negedge clk_50);
                sig_in = 1'b0;
                repeat (gen_lo) @(negedge clk_50);
            end
        end
    end

    // scoreboard
    int             tests = 0;
    int             fails = 0;
    logic [EW-1:0]  exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " timeout"},   64'(bus.timeout),   64'(e[EW-1]));
            check({tag, " period"},    64'(bus.period),    64'(e[2*CNT_W-1:CNT_W]));
            check({tag, " high_time"}, 64'(bus.high_time), 64'(e[CNT_W-1:0]));
        end
    endtask

    // driver tasks
    task automatic set_wave(input int hi, input int lo);
        gen_hi   = hi;
        gen_lo   = lo;
        gen_mode = 1'b0;
        repeat (150) @(posedge clk_50);
    endtask

    task automatic set_level(input logic lvl);
        gen_level = lvl;
        gen_mode  = 1'b1;
        repeat (100) @(posedge clk_50);
    endtask

    task automatic pulse_start();
        @(negedge clk_50);
        bus.start = 1'b1;
        @(posedge clk_50);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        while (waited < budget && !ok) begin
            @(posedge clk_50);
            #1;
            waited++;
            if (bus.valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk_50);
        bus.rdy = 1'b1;
        @(posedge clk_50);
        #1;
        bus.rdy = 1'b0;
        check({tag, " valid after handshake"}, 64'(bus.valid), 64'd0);
        check({tag, " busy after handshake"},  64'(bus.busy),  64'd0);
    endtask

    task automatic run_meas(input int hi, input int lo, input string tag);
        int w;
        bit ok;
        set_wave(hi, lo);
        pulse_start();
        exp_q.push_back({1'b0, CNT_W'(hi + lo), CNT_W'(hi)});
        wait_valid(300, w, ok);
        check({tag, " valid seen"}, 64'(ok), 64'd1);
        if (ok) begin
            check_result(tag);
            check({tag, " busy in DONE"}, 64'(bus.busy), 64'd1);
            handshake(tag);
        end
    endtask

    initial begin
        int  w;
        bit  ok;
        bit  stable;
        bit  seen;
        logic [CNT_W-1:0] p0, h0;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.rdy   = 1'b0;

        // reset with sig_in toggling
        gen_hi = 1; gen_lo = 1; gen_mode = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        check("reset busy",      64'(bus.busy),      64'd0);
        check("reset valid",     64'(bus.valid),     64'd0);
        check("reset timeout",   64'(bus.timeout),   64'd0);
        check("reset period",    64'(bus.period),    64'd0);
        check("reset high_time", 64'(bus.high_time), 64'd0);
        check("reset state",     64'(dbg.state),     64'(IDLE));
        @(negedge clk_50);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (100) begin
            @(posedge clk_50);
            #1;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        check("idle without start", 64'(seen), 64'd0);

`ifndef PERIOD_METER_AUTO_EN
        // symmetric 8/8
        run_meas(8, 8, "sym8");

        // asymmetric 3/7 with rdy held low, then start during DONE ignored
        set_wave(3, 7);
        pulse_start();
        exp_q.push_back({1'b0, CNT_W'(10), CNT_W'(3)});
        wait_valid(300, w, ok);
        check("asym valid seen", 64'(ok), 64'd1);
        check_result("asym");
        p0 = bus.period;
        h0 = bus.high_time;
        stable = 1'b1;
        @(negedge clk_50);
        bus.start = 1'b1;
        repeat (20) begin
            @(posedge clk_50);
            #1;
            if (bus.valid !== 1'b1 || bus.period !== p0 || bus.high_time !== h0 ||
                bus.timeout !== 1'b0) stable = 1'b0;
        end
        check("asym stable while rdy=0", 64'(stable), 64'd1);
        handshake("asym");
        @(negedge clk_50);
        bus.start = 1'b0;
        check("asym state idle", 64'(dbg.state), 64'(IDLE));
        check("asym results kept", 64'({bus.period, bus.high_time}), 64'({CNT_W'(10), CNT_W'(3)}));
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk_50);
            #1;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        check("start in DONE ignored", 64'(seen), 64'd0);

        // randomized waveforms
        for (int i = 0; i < 8; i++) begin
            run_meas($urandom_range(1, 20), $urandom_range(1, 20), "rand");
        end

        // timeout, input stuck low
        set_level(1'b0);
        pulse_start();
        exp_q.push_back({1'b1, CNT_W'(0), CNT_W'(0)});
        wait_valid(2 * TMO, w, ok);
        check("tmo0 valid seen", 64'(ok), 64'd1);
        check("tmo0 latency", 64'(w), 64'(TMO));
        check_result("tmo0");
        handshake("tmo0");

        // timeout, input stuck high after one rising edge
        pulse_start();
        exp_q.push_back({1'b1, CNT_W'(0), CNT_W'(0)});
        repeat (5) @(posedge clk_50);
        gen_level = 1'b1;
        wait_valid(2 * TMO, w, ok);
        check("tmo1 valid seen", 64'(ok), 64'd1);
        check_result("tmo1");
        handshake("tmo1");

        // reset during MEAS_LOW, then a fresh measurement
        set_wave(10, 10);
        pulse_start();
        w  = 0;
        ok = 1'b0;
        while (w < 300 && !ok) begin
            @(posedge clk_50);
            #1;
            w++;
            if (dbg.state == MEAS_LOW) ok = 1'b1;
        end
        check("reach MEAS_LOW", 64'(ok), 64'd1);
        @(negedge clk_50);
        reset = 1'b1;
        @(posedge clk_50);
        #1;
        check("midreset state", 64'(dbg.state), 64'(IDLE));
        check("midreset valid", 64'(bus.valid), 64'd0);
        check("midreset busy",  64'(bus.busy),  64'd0);
        @(negedge clk_50);
        reset = 1'b0;
        run_meas(4, 6, "after reset");
`else
        // continuous mode with rdy tied high
        @(negedge clk_50);
        bus.rdy = 1'b1;
        set_wave(5, 5);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b0, CNT_W'(10), CNT_W'(5)});
            wait_valid(300, w, ok);
            check("auto valid seen", 64'(ok), 64'd1);
            check_result("auto");
            check("auto busy", 64'(bus.busy), 64'd1);
        end
        @(posedge clk_50);
        #1;
        check("auto busy after handshake", 64'(bus.busy), 64'd1);
        bus.rdy = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
